// File: rtl/fmap_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmap_stream_tx
// Brief    : Fills a binary feature-map frame store via valid/ready, then
//            replays the whole frame in raster order, one pixel per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fmap_stream_tx #(
    parameter int WIDTH        = 13,
    parameter int HEIGHT       = 13,
    parameter int NUM_CHANNELS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] in_pixel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CHANNELS-1:0] pixel_out,
    output logic                    valid_out,
    output logic                    frame_first,
    output logic                    frame_last
);

    localparam int              C_N    = WIDTH * HEIGHT;
    localparam int              C_AW   = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_AW-1:0] C_LAST = C_AW'(C_N - 1);

    typedef enum logic [0:0] {
        S_FILL   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [C_AW-1:0]         wr_addr_q, wr_addr_d;
    logic [C_AW-1:0]         rd_addr_q, rd_addr_d;
    logic                    ready_en_q;
    logic [NUM_CHANNELS-1:0] pixel_q, pixel_d;
    logic                    valid_q, valid_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic [NUM_CHANNELS-1:0] store_q [C_N];
    logic                    w_accept;

    // ready_en_q holds in_ready low through reset and for the release cycle
    assign in_ready    = ready_en_q && (state_q == S_FILL);
    assign w_accept    = in_valid && in_ready;
    assign pixel_out   = pixel_q;
    assign valid_out   = valid_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        pixel_d   = '0;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (w_accept) begin
                    if (wr_addr_q == C_LAST) begin
                        wr_addr_d = '0;
                        state_d   = S_STREAM;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                pixel_d = store_q[rd_addr_q];
                valid_d = 1'b1;
                first_d = (rd_addr_q == '0);
                last_d  = (rd_addr_q == C_LAST);
                if (rd_addr_q == C_LAST) begin
                    rd_addr_d = '0;
                    state_d   = S_FILL;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            ready_en_q <= 1'b0;
            pixel_q    <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            ready_en_q <= 1'b1;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

    // Store is deliberately left uncleared by reset; a full refill precedes any read.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            store_q[wr_addr_q] <= in_pixel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmap_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fmap_stream_tx
// Brief    : Self-checking bench: table of frames plus reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_stream_tx;

    localparam int W  = 13;
    localparam int H  = 13;
    localparam int NC = 8;
    localparam int N  = W * H;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [NC-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NC-1:0] pixel_out;
    logic          valid_out;
    logic          frame_first;
    logic          frame_last;

    always #5 clk = ~clk;

    fmap_stream_tx #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .NUM_CHANNELS (NC)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_pixel    (in_pixel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pixel_out   (pixel_out),
        .valid_out   (valid_out),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    typedef struct {
        logic [7:0] mask;
        int         duty;
        bit         hold;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t       vecs [4];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb [$];
    bit         mon_en = 1'b0;
    bit         seen_valid = 1'b0;
    int         idx = 0;
    int         frames_done = 0;
    logic [7:0] cap_first [8];
    logic [7:0] cap_last  [8];
    logic [7:0] exp_px;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard for each replayed pixel
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                seen_valid = 1'b1;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(pixel_out), 32'hFFFF_FFFF);
                end else begin
                    exp_px = sb.pop_front();
                    check("pixel", 32'(pixel_out), 32'(exp_px));
                end
                check("frame_first", 32'(frame_first), 32'(idx == 0));
                check("frame_last", 32'(frame_last), 32'(idx == N - 1));
                check("in_ready_stream", 32'(in_ready), 32'(idx == N - 1));
                if (idx == 0 && frames_done < 8) cap_first[frames_done] = pixel_out;
                if (idx == N - 1) begin
                    if (frames_done < 8) cap_last[frames_done] = pixel_out;
                    frames_done++;
                    idx = 0;
                end else begin
                    idx++;
                end
            end else begin
                check("idle_outputs", 32'({pixel_out, frame_first, frame_last}), 32'd0);
                check("no_gap", 32'(idx), 32'd0);
                idx = 0;
            end
        end
    end

    // Called at posedge+1; in_ready is settled, so the accept is known when driving
    task automatic send_frame(input logic [7:0] mask, input int duty, input bit hold);
        int a = 0;
        int budget = 0;
        while (a < N) begin
            if (!in_ready && hold) begin
                in_valid = 1'b1;
                in_pixel = 8'h5A;
            end else begin
                in_valid = ($urandom_range(99) < duty);
                in_pixel = 8'(a) ^ mask;
            end
            if (in_valid && in_ready) begin
                sb.push_back(8'(a) ^ mask);
                a++;
            end
            @(posedge clk);
            #1;
            budget++;
            if (budget > 5000) begin
                check("fill_timeout", 32'(a), 32'(N));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames_done < target && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("frames_done", 32'(frames_done), 32'(target));
    endtask

    initial begin
        int t;
        vecs[0] = '{8'h00, 100, 1'b0, 8'h00, 8'hA8};  // contiguous
        vecs[1] = '{8'hFF,  30, 1'b0, 8'hFF, 8'h57};  // bubbly, inverted
        vecs[2] = '{8'h00, 100, 1'b1, 8'h00, 8'hA8};  // 0x5A held during prior replay
        vecs[3] = '{8'h3C, 100, 1'b0, 8'h3C, 8'h94};  // back-to-back, XOR 0x3C

        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'h77;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_outputs",
                  32'({in_ready, valid_out, frame_first, frame_last, pixel_out}), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        for (int k = 0; k < 4; k++) begin
            send_frame(vecs[k].mask, vecs[k].duty, vecs[k].hold);
        end
        wait_frames(4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("vec%0d_first", k), 32'(cap_first[k]), 32'(vecs[k].exp_first));
            check($sformatf("vec%0d_last", k), 32'(cap_last[k]), 32'(vecs[k].exp_last));
        end

        // Abort a replay at pixel 50 with reset
        send_frame(8'h99, 100, 1'b0);
        t = 0;
        while (idx != 51 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reached_pixel_50", 32'(idx), 32'd51);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("valid_after_mid_reset", 32'({valid_out, frame_first, frame_last, in_ready}), 32'd0);
        sb.delete();
        idx = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_mid_reset", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        mon_en     = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("no_replay_after_abort", 32'(seen_valid), 32'd0);

        send_frame(8'h66, 50, 1'b0);
        check("no_early_valid", 32'(seen_valid), 32'd0);
        wait_frames(5);
        check("refill_first", 32'(cap_first[4]), 32'h66);
        check("refill_last", 32'(cap_last[4]), 32'hCE);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
